iob_ila_capture: RTL and testbench

IOB_ILA_CAPTURE -- requirements
Module: iob_ila_capture

---
 rtl/iob_ila_capture_if.sv | 33 +++
 rtl/iob_ila_capture.sv | 90 +++++++++
 tb/tb_iob_ila_capture.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/iob_ila_capture_if.sv
// iob_ila_capture_if: capture control, trigger configuration, status and readback bundle
interface iob_ila_capture_if #(
  parameter int SIGNAL_W  = 32,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4
);
  logic [SIGNAL_W-1:0]  signal;
  logic [TRIGGER_W-1:0] trigger;
  logic [TRIGGER_W-1:0] trigger_type;
  logic [TRIGGER_W-1:0] trigger_negate;
  logic [TRIGGER_W-1:0] trigger_mask;
  logic                 reduce_and;
  logic [BUFFER_W-1:0]  post_count;
  logic                 arm;
  logic                 abort;
  logic [1:0]           state;
  logic                 triggered;
  logic                 done;
  logic [BUFFER_W:0]    n_samples;
  logic [BUFFER_W-1:0]  trigger_index;
  logic [BUFFER_W-1:0]  read_index;
  logic [SIGNAL_W-1:0]  read_data;
  modport master (
    output signal, trigger, trigger_type, trigger_negate, trigger_mask, reduce_and,
           post_count, arm, abort, read_index,
    input  state, triggered, done, n_samples, trigger_index, read_data
  );
  modport slave (
    input  signal, trigger, trigger_type, trigger_negate, trigger_mask, reduce_and,
           post_count, arm, abort, read_index,
    output state, triggered, done, n_samples, trigger_index, read_data
  );
endinterface

// File: rtl/iob_ila_capture.sv
// iob_ila_capture: circular sample buffer with pre/post trigger capture and oldest-first readback
module iob_ila_capture #(
  parameter int SIGNAL_W  = 32,
  parameter int BUFFER_W  = 10,
  parameter int TRIGGER_W = 4
) (
  input logic clk,
  input logic rst,
  iob_ila_capture_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
  localparam logic [BUFFER_W:0] DEPTH = {1'b1, {BUFFER_W{1'b0}}};
  state_t               state_q, state_d;
  logic [TRIGGER_W-1:0] c, ev, c_prev_q;
  logic                 cond, we, trig_q, trig_d, done_q;
  logic [BUFFER_W:0]    n_q, n_d;
  logic [BUFFER_W-1:0]  wptr_q, wptr_d, tidx_q, tidx_d, rem_q, rem_d, raddr;
  logic [SIGNAL_W-1:0]  read_data_q;
  logic [SIGNAL_W-1:0]  mem [1 << BUFFER_W];
  assign c     = bus.trigger ^ bus.trigger_negate;
  assign ev    = (bus.trigger_type & c & ~c_prev_q) | (~bus.trigger_type & c);
  assign cond  = |bus.trigger_mask &&
                 (bus.reduce_and ? &(ev | ~bus.trigger_mask) : |(ev & bus.trigger_mask));
  assign raddr = wptr_q - n_q[BUFFER_W-1:0] + bus.read_index;
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    wptr_d  = wptr_q;
    tidx_d  = tidx_q;
    rem_d   = rem_q;
    trig_d  = trig_q;
    we      = 1'b0;
    if (bus.abort && (state_q == PRE || state_q == POST)) begin
      state_d = DONE;
    end else if (bus.arm && !bus.abort) begin
      state_d = PRE;
      n_d     = '0;
      wptr_d  = '0;
      tidx_d  = '0;
      trig_d  = 1'b0;
    end else if (state_q == PRE || state_q == POST) begin
      we     = 1'b1;
      wptr_d = wptr_q + BUFFER_W'(1);
      n_d    = (n_q == DEPTH) ? n_q : n_q + (BUFFER_W+1)'(1);
      // Once full, each new write drops the oldest sample, shifting the trigger's read index down
      if (state_q == POST) begin
        tidx_d  = (n_q == DEPTH) ? tidx_q - BUFFER_W'(1) : tidx_q;
        rem_d   = rem_q - BUFFER_W'(1);
        state_d = (rem_q == BUFFER_W'(1)) ? DONE : POST;
      end else if (cond) begin
        trig_d  = 1'b1;
        tidx_d  = n_d[BUFFER_W-1:0] - BUFFER_W'(1);
        rem_d   = bus.post_count;
        state_d = (bus.post_count == '0) ? DONE : POST;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      wptr_q      <= '0;
      tidx_q      <= '0;
      rem_q       <= '0;
      trig_q      <= 1'b0;
      done_q      <= 1'b0;
      c_prev_q    <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      wptr_q      <= wptr_d;
      tidx_q      <= tidx_d;
      rem_q       <= rem_d;
      trig_q      <= trig_d;
      done_q      <= (state_d == DONE);
      c_prev_q    <= c;
      read_data_q <= mem[raddr];
    end
  end
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wptr_q] <= bus.signal;
  end
  assign bus.state         = state_q;
  assign bus.triggered     = trig_q;
  assign bus.done          = done_q;
  assign bus.n_samples     = n_q;
  assign bus.trigger_index = tidx_q;
  assign bus.read_data     = read_data_q;
endmodule

// File: tb/tb_iob_ila_capture.sv
// tb_iob_ila_capture: directed capture scenarios checked through an expectation queue and monitor
module tb_iob_ila_capture;
  localparam int SW = 8, BW = 4, TW = 4;
  typedef enum int {ST, TRG, DN, NS, TI, RD} sel_t;
  typedef struct {sel_t id; logic [31:0] val; string name;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [SW-1:0] cnt = '0;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  logic [SW-1:0] tv;
  iob_ila_capture_if #(.SIGNAL_W(SW), .BUFFER_W(BW), .TRIGGER_W(TW)) bus ();
  iob_ila_capture #(.SIGNAL_W(SW), .BUFFER_W(BW), .TRIGGER_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 8'd1;
  assign bus.signal = cnt;
  function automatic logic [31:0] actual(sel_t id);
    case (id)
      ST:      return 32'(bus.state);
      TRG:     return 32'(bus.triggered);
      DN:      return 32'(bus.done);
      NS:      return 32'(bus.n_samples);
      TI:      return 32'(bus.trigger_index);
      default: return 32'(bus.read_data);
    endcase
  endfunction
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      automatic exp_t e = exp_q.pop_front();
      automatic logic [31:0] a = actual(e.id);
      checks++;
      if (a !== e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d at %0t", e.name, a, e.val, $time);
      end
    end
  end
  task automatic check_now(logic [31:0] a, logic [31:0] v, string name);
    checks++;
    if (a !== v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, a, v, $time);
    end
  endtask
  task automatic expect_v(sel_t id, logic [31:0] v, string name);
    exp_q.push_back('{id, v, name});
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic arm_pulse();
    bus.arm = 1'b1;
    step(1);
    bus.arm = 1'b0;
  endtask
  task automatic expect_status(logic [1:0] st, logic trg, logic [4:0] ns, logic [3:0] ti, string tag);
    expect_v(ST, 32'(st), {tag, "_state"});
    expect_v(TRG, 32'(trg), {tag, "_triggered"});
    expect_v(DN, 32'(st == 2'd3), {tag, "_done"});
    expect_v(NS, 32'(ns), {tag, "_n_samples"});
    expect_v(TI, 32'(ti), {tag, "_trigger_index"});
  endtask
  task automatic expect_read(logic [3:0] idx, logic [SW-1:0] v, string name);
    bus.read_index = idx;
    step(1);
    expect_v(RD, 32'(v), name);
  endtask
  initial begin
    bus.trigger = '0; bus.trigger_type = '0; bus.trigger_negate = '0; bus.trigger_mask = '0;
    bus.reduce_and = 1'b0; bus.post_count = '0; bus.arm = 1'b0; bus.abort = 1'b0; bus.read_index = '0;
    step(3);
    rst = 1'b0;
    check_now(32'(bus.state), 32'd0, "reset_state_now");
    check_now(32'(bus.n_samples), 32'd0, "reset_n_samples_now");
    expect_status(2'd0, 1'b0, 5'd0, 4'd0, "reset");
    expect_v(RD, 32'd0, "reset_read_data");
    step(1);
    bus.trigger_mask = 4'b0001; bus.post_count = 4'd3;
    arm_pulse();
    expect_v(ST, 32'd1, "lvl_pre");
    step(20);
    bus.trigger = 4'b0001; tv = cnt;
    step(1);
    bus.trigger = '0;
    expect_status(2'd2, 1'b1, 5'd16, 4'd15, "lvl_trig");
    step(3);
    expect_status(2'd3, 1'b1, 5'd16, 4'd12, "lvl_done");
    step(2);
    expect_v(NS, 32'd16, "lvl_hold_n");
    expect_read(4'd12, tv, "lvl_read_trig");
    expect_read(4'd15, tv + 8'd3, "lvl_read_last");
    expect_read(4'd0, tv - 8'd12, "lvl_read_oldest");
    bus.trigger_type = 4'b0010; bus.trigger_negate = 4'b0010; bus.trigger_mask = 4'b0010;
    bus.post_count = 4'd2; bus.trigger = 4'b0010;
    step(1);
    arm_pulse();
    step(3);
    expect_status(2'd1, 1'b0, 5'd3, 4'd0, "edge_wait");
    bus.trigger = 4'b0000; tv = cnt;
    step(1);
    expect_status(2'd2, 1'b1, 5'd4, 4'd3, "edge_trig");
    step(2);
    expect_status(2'd3, 1'b1, 5'd6, 4'd3, "edge_done");
    expect_read(4'd3, tv, "edge_read_trig");
    arm_pulse();
    step(5);
    expect_status(2'd1, 1'b0, 5'd5, 4'd0, "edge_no_retrig");
    bus.trigger_type = '0; bus.trigger_negate = '0; bus.trigger_mask = 4'b0011;
    bus.reduce_and = 1'b1; bus.post_count = 4'd0; bus.trigger = 4'b0001;
    arm_pulse();
    step(4);
    expect_status(2'd1, 1'b0, 5'd4, 4'd0, "and_one_high");
    bus.trigger = 4'b0011;
    step(1);
    expect_status(2'd3, 1'b1, 5'd5, 4'd4, "and_both_high");
    bus.trigger_mask = 4'b0000; bus.reduce_and = 1'b0; bus.trigger = 4'b1111;
    arm_pulse();
    step(30);
    check_now(32'(bus.state), 32'd1, "mask0_wait_expired_now");
    expect_status(2'd1, 1'b0, 5'd16, 4'd0, "mask0_or");
    bus.reduce_and = 1'b1;
    step(3);
    expect_status(2'd1, 1'b0, 5'd16, 4'd0, "mask0_and");
    bus.abort = 1'b1; step(1); bus.abort = 1'b0;
    bus.trigger_mask = 4'b0001; bus.reduce_and = 1'b0; bus.trigger = '0; bus.post_count = 4'd0;
    arm_pulse();
    step(1);
    bus.trigger = 4'b0001;
    step(1);
    bus.trigger = '0;
    expect_status(2'd3, 1'b1, 5'd2, 4'd1, "early_pc0");
    bus.post_count = 4'd15;
    arm_pulse();
    step(1);
    bus.trigger = 4'b0001; tv = cnt;
    step(1);
    bus.trigger = '0;
    expect_status(2'd2, 1'b1, 5'd2, 4'd1, "early_pc15_trig");
    step(14);
    expect_v(ST, 32'd2, "early_pc15_still_post");
    step(1);
    expect_status(2'd3, 1'b1, 5'd16, 4'd0, "early_pc15_done");
    expect_read(4'd0, tv, "early_read_trig");
    bus.post_count = 4'd5;
    arm_pulse();
    step(5);
    bus.abort = 1'b1; step(1); bus.abort = 1'b0;
    expect_status(2'd3, 1'b0, 5'd5, 4'd0, "abort_pre");
    bus.abort = 1'b1; step(1); bus.abort = 1'b0;
    expect_status(2'd3, 1'b0, 5'd5, 4'd0, "abort_in_done");
    arm_pulse();
    step(2);
    bus.arm = 1'b1; bus.abort = 1'b1; step(1); bus.arm = 1'b0; bus.abort = 1'b0;
    expect_status(2'd3, 1'b0, 5'd2, 4'd0, "arm_abort");
    arm_pulse();
    step(2);
    bus.trigger = 4'b0001;
    step(1);
    bus.trigger = '0;
    expect_status(2'd2, 1'b1, 5'd3, 4'd2, "rst_pre_post");
    rst = 1'b1; bus.arm = 1'b1; step(1); rst = 1'b0; bus.arm = 1'b0;
    expect_status(2'd0, 1'b0, 5'd0, 4'd0, "rst_post");
    expect_v(RD, 32'd0, "rst_read_data");
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
